// File: rtl/qspi_flash_sequencer.sv
// Flash command sequencer in front of qspi_master: expands host requests into
// WREN / program / erase / read / status-poll sub-transactions.
module qspi_flash_sequencer #(
    parameter int POLL_MAX     = 1023,
    parameter int DUMMY_CYCLES = 10
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_quad,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    output logic [31:0] m_cmd,
    output logic [5:0]  m_cmd_len,
    output logic [31:0] m_addr,
    output logic [5:0]  m_addr_len,
    output logic [15:0] m_dummy_len,
    output logic [15:0] m_data_len,
    output logic        m_wr,
    output logic        m_rd,
    output logic        m_qwr,
    output logic        m_qrd,

    output logic        m_tx_valid,
    output logic [31:0] m_tx_bits,
    input  logic        m_tx_ready,
    input  logic        m_rx_valid,
    input  logic [31:0] m_rx_bits,
    output logic        m_rx_ready,
    input  logic        m_tx_done,
    input  logic        m_rx_done
);

    localparam int PW = $clog2(POLL_MAX + 1);

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_PROGRAM = 2'b01;
    localparam logic [1:0] OP_STATUS  = 2'b10;
    localparam logic [1:0] OP_ERASE   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_OP, S_POLL, S_CHECK, S_GAP, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          wait_q;        // 0 = ISSUE phase, 1 = WAIT phase
    logic          gap_cnt_q;
    logic          gap_to_op_q;
    logic [PW-1:0] poll_cnt_q;
    logic          alive_q;
    logic [1:0]    op_q;
    logic          quad_q;
    logic [23:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          tx_sent_q;
    logic          rx_got_q;

    logic accept;
    logic op_is_read;
    logic sub_active;
    logic sub_is_read;
    logic sub_done;
    logic poll_expired;

    assign accept       = req_valid & req_ready;
    assign op_is_read   = (op_q == OP_READ) || (op_q == OP_STATUS);
    assign sub_active   = (state_q == S_WREN) || (state_q == S_OP) || (state_q == S_POLL);
    assign sub_is_read  = (state_q == S_POLL) || ((state_q == S_OP) && op_is_read);
    // Only the done pulse matching the sub-transaction direction ends WAIT.
    assign sub_done     = sub_active & wait_q & (sub_is_read ? m_rx_done : m_tx_done);
    assign poll_expired = poll_cnt_q >= PW'(POLL_MAX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept)
                         state_d = (req_op == OP_READ || req_op == OP_STATUS) ? S_OP : S_WREN;
            S_WREN:  if (sub_done) state_d = S_GAP;
            S_OP:    if (sub_done) state_d = op_is_read ? S_RESP : S_GAP;
            S_GAP:   if (gap_cnt_q) state_d = gap_to_op_q ? S_OP : S_POLL;
            S_POLL:  if (sub_done) state_d = S_CHECK;
            S_CHECK: state_d = (!rdata_q[0] || poll_expired) ? S_RESP : S_GAP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alive_q     <= 1'b0;
            wait_q      <= 1'b0;
            gap_cnt_q   <= 1'b0;
            gap_to_op_q <= 1'b0;
            poll_cnt_q  <= '0;
            op_q        <= OP_READ;
            quad_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tx_sent_q   <= 1'b0;
            rx_got_q    <= 1'b0;
        end else begin
            alive_q   <= 1'b1;
            wait_q    <= sub_active && (state_d == state_q);
            gap_cnt_q <= (state_q == S_GAP) && !gap_cnt_q;

            if (state_d == S_GAP && state_q != S_GAP)
                gap_to_op_q <= (state_q == S_WREN);

            if (accept) begin
                op_q       <= req_op;
                quad_q     <= req_quad;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                rdata_q    <= '0;
                err_q      <= 1'b0;
                poll_cnt_q <= '0;
            end

            if (!wait_q)
                tx_sent_q <= 1'b0;
            else if (m_tx_valid && m_tx_ready)
                tx_sent_q <= 1'b1;

            if (!wait_q) begin
                rx_got_q <= 1'b0;
            end else if (m_rx_valid && m_rx_ready && !rx_got_q) begin
                rx_got_q <= 1'b1;
                rdata_q  <= (state_q == S_OP && op_q == OP_READ) ? m_rx_bits
                                                                  : {24'h0, m_rx_bits[7:0]};
            end

            if (state_q == S_POLL && sub_done)
                poll_cnt_q <= poll_cnt_q + 1'b1;

            if (state_q == S_CHECK && rdata_q[0] && poll_expired)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        req_ready   = alive_q && (state_q == S_IDLE);
        resp_valid  = (state_q == S_RESP);
        resp_rdata  = resp_valid ? rdata_q : '0;
        resp_err    = resp_valid & err_q;

        m_cmd       = '0;
        m_cmd_len   = '0;
        m_addr      = '0;
        m_addr_len  = '0;
        m_dummy_len = '0;
        m_data_len  = '0;
        m_wr        = 1'b0;
        m_rd        = 1'b0;
        m_qwr       = 1'b0;
        m_qrd       = 1'b0;
        m_tx_valid  = 1'b0;
        m_tx_bits   = '0;
        m_rx_ready  = 1'b0;

        if (sub_active) begin
            m_cmd_len  = 6'd8;
            m_wr       = !sub_is_read && !quad_q;
            m_qwr      = !sub_is_read &&  quad_q;
            m_rd       =  sub_is_read && !quad_q;
            m_qrd      =  sub_is_read &&  quad_q;
            m_rx_ready =  sub_is_read &&  wait_q;

            case (state_q)
                S_WREN: m_cmd = {8'h06, 24'h0};
                S_POLL: begin
                    m_cmd      = {8'h05, 24'h0};
                    m_data_len = 16'd8;
                end
                default: begin
                    case (op_q)
                        OP_READ: begin
                            m_cmd       = {(quad_q ? 8'h6B : 8'h03), 24'h0};
                            m_addr      = {addr_q, 8'h00};
                            m_addr_len  = 6'd24;
                            m_dummy_len = quad_q ? 16'(DUMMY_CYCLES) : 16'd0;
                            m_data_len  = 16'd32;
                        end
                        OP_PROGRAM: begin
                            m_cmd      = {(quad_q ? 8'h32 : 8'h02), 24'h0};
                            m_addr     = {addr_q, 8'h00};
                            m_addr_len = 6'd24;
                            m_data_len = 16'd32;
                            m_tx_valid = wait_q && !tx_sent_q;
                            m_tx_bits  = wdata_q;
                        end
                        OP_STATUS: begin
                            m_cmd      = {8'h05, 24'h0};
                            m_data_len = 16'd8;
                        end
                        default: begin
                            m_cmd      = {8'h20, 24'h0};
                            m_addr     = {addr_q, 8'h00};
                            m_addr_len = 6'd24;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// Directed bench for qspi_flash_sequencer: a scripted qspi_master stand-in
// serves each sub-transaction and records what the sequencer asked for.
module tb_qspi_flash_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic        req_quad = 1'b0;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] m_cmd;
    logic [5:0]  m_cmd_len;
    logic [31:0] m_addr;
    logic [5:0]  m_addr_len;
    logic [15:0] m_dummy_len;
    logic [15:0] m_data_len;
    logic        m_wr, m_rd, m_qwr, m_qrd;
    logic        m_tx_valid;
    logic [31:0] m_tx_bits;
    logic        m_tx_ready = 1'b0;
    logic        m_rx_valid = 1'b0;
    logic [31:0] m_rx_bits = '0;
    logic        m_rx_ready;
    logic        m_tx_done = 1'b0;
    logic        m_rx_done = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    qspi_flash_sequencer #(.POLL_MAX(4), .DUMMY_CYCLES(10)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_quad(req_quad), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_cmd(m_cmd), .m_cmd_len(m_cmd_len), .m_addr(m_addr), .m_addr_len(m_addr_len),
        .m_dummy_len(m_dummy_len), .m_data_len(m_data_len),
        .m_wr(m_wr), .m_rd(m_rd), .m_qwr(m_qwr), .m_qrd(m_qrd),
        .m_tx_valid(m_tx_valid), .m_tx_bits(m_tx_bits), .m_tx_ready(m_tx_ready),
        .m_rx_valid(m_rx_valid), .m_rx_bits(m_rx_bits), .m_rx_ready(m_rx_ready),
        .m_tx_done(m_tx_done), .m_rx_done(m_rx_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] cmd;
        logic [5:0]  cmd_len;
        logic [31:0] addr;
        logic [5:0]  addr_len;
        logic [15:0] dummy;
        logic [15:0] dlen;
        logic [3:0]  stb;
        int          gap;
        logic [31:0] txw;
        int          beats;
        bit          rxr;
        bit          stable;
        bit          dropped;
    } xact_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // {m_wr, m_qwr, m_rd, m_qrd}
    function automatic logic [3:0] stb_now();
        return {m_wr, m_qwr, m_rd, m_qrd};
    endfunction

    function automatic logic [31:0] any_out();
        return 32'(|{req_ready, resp_valid, resp_rdata, resp_err, m_cmd, m_cmd_len,
                     m_addr, m_addr_len, m_dummy_len, m_data_len, m_wr, m_rd, m_qwr,
                     m_qrd, m_tx_valid, m_tx_bits, m_rx_ready});
    endfunction

    function automatic bit same(input xact_t x);
        return m_cmd == x.cmd && m_cmd_len == x.cmd_len && m_addr == x.addr &&
               m_addr_len == x.addr_len && m_dummy_len == x.dummy &&
               m_data_len == x.dlen && stb_now() == x.stb;
    endfunction

    task automatic do_req(input logic [1:0] op, input logic q, input logic [23:0] a,
                          input logic [31:0] w);
        int guard = 0;
        req_valid = 1'b1; req_op = op; req_quad = q; req_addr = a; req_wdata = w;
        while (!req_ready && guard < 50) begin tick(); guard++; end
        check("req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // stray: matching done pulsed during ISSUE, opposite done pulsed during WAIT
    task automatic serve(input logic [31:0] rx, input bit stray, output xact_t x);
        int  guard = 0;
        bit  is_wr;
        x = '{default: 0};
        x.stable = 1'b1;
        while (stb_now() == 4'b0 && guard < 50) begin tick(); x.gap++; guard++; end
        check("strobe_seen", 32'(stb_now() != 4'b0), 32'd1);
        if (stb_now() == 4'b0) return;
        x.cmd = m_cmd; x.cmd_len = m_cmd_len; x.addr = m_addr; x.addr_len = m_addr_len;
        x.dummy = m_dummy_len; x.dlen = m_data_len; x.stb = stb_now();
        is_wr = m_wr | m_qwr;
        if (stray) begin
            if (is_wr) m_tx_done = 1'b1; else m_rx_done = 1'b1;
        end
        tick();
        m_tx_done = 1'b0; m_rx_done = 1'b0;
        x.stable &= same(x);
        x.rxr = m_rx_ready;
        if (is_wr) begin
            if (m_tx_valid) begin
                m_tx_ready = 1'b1; x.txw = m_tx_bits; x.beats = 1;
                tick();
                m_tx_ready = 1'b0;
                x.stable &= same(x);
                if (m_tx_valid) x.beats++;
            end
            if (stray) begin m_rx_done = 1'b1; tick(); m_rx_done = 1'b0; x.stable &= same(x); end
            m_tx_done = 1'b1; tick(); m_tx_done = 1'b0;
        end else begin
            m_rx_valid = 1'b1; m_rx_bits = rx;
            tick(); x.stable &= same(x);
            m_rx_bits = ~rx;
            tick(); x.stable &= same(x);
            m_rx_valid = 1'b0; m_rx_bits = '0;
            if (stray) begin m_tx_done = 1'b1; tick(); m_tx_done = 1'b0; x.stable &= same(x); end
            m_rx_done = 1'b1; tick(); m_rx_done = 1'b0;
        end
        x.dropped = (stb_now() == 4'b0);
    endtask

    task automatic chk_x(input string p, input xact_t x, input logic [31:0] cmd,
                         input logic [31:0] addr, input logic [5:0] alen,
                         input logic [15:0] dummy, input logic [15:0] dlen,
                         input logic [3:0] stb, input int gap);
        check({p, "_cmd"},     x.cmd, cmd);
        check({p, "_cmd_len"}, 32'(x.cmd_len), 32'd8);
        check({p, "_addr"},    x.addr, addr);
        check({p, "_addr_len"}, 32'(x.addr_len), 32'(alen));
        check({p, "_dummy"},   32'(x.dummy), 32'(dummy));
        check({p, "_dlen"},    32'(x.dlen), 32'(dlen));
        check({p, "_strobe"},  32'(x.stb), 32'(stb));
        check({p, "_gap"},     32'(x.gap), 32'(gap));
        check({p, "_stable"},  32'(x.stable), 32'd1);
        check({p, "_dropped"}, 32'(x.dropped), 32'd1);
    endtask

    task automatic get_resp(input string p, input int hold, output logic [31:0] rdata,
                            output logic err, output int lat);
        int stray_stb = 0;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            if (stb_now() != 4'b0) stray_stb++;
            tick(); lat++;
        end
        check({p, "_resp_seen"}, 32'(resp_valid), 32'd1);
        check({p, "_no_strobe"}, 32'(stray_stb + int'(stb_now() != 4'b0)), 32'd0);
        check({p, "_busy"}, 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({p, "_hold_valid"}, 32'(resp_valid), 32'd1);
            check({p, "_hold_busy"}, 32'(req_ready), 32'd0);
        end
        rdata = resp_rdata; err = resp_err;
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
        check({p, "_resp_drop"}, 32'(resp_valid), 32'd0);
        check({p, "_idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        xact_t       x;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          guard;

        // Reset state
        #12;
        check("rst_outputs", any_out(), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clock); reset = 1'b1;
        tick();
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);

        // Single READ
        do_req(2'b00, 1'b0, 24'h000600, 32'h0);
        serve(32'h12345678, 1'b0, x);
        chk_x("rd", x, 32'h03000000, 32'h00060000, 6'd24, 16'd0, 16'd32, 4'b0010, 0);
        check("rd_rx_ready", 32'(x.rxr), 32'd1);
        get_resp("rd", 0, rd, er, lat);
        check("rd_rdata", rd, 32'h12345678);
        check("rd_err", 32'(er), 32'd0);
        check("rd_latency", 32'(lat), 32'd0);

        // Quad PROGRAM with WIP 1,1,0
        do_req(2'b01, 1'b1, 24'h00ABCD, 32'h12345678);
        serve(32'h0, 1'b0, x);
        chk_x("pp_wren", x, 32'h06000000, 32'h0, 6'd0, 16'd0, 16'd0, 4'b0100, 0);
        check("pp_wren_beats", 32'(x.beats), 32'd0);
        serve(32'h0, 1'b0, x);
        chk_x("pp_op", x, 32'h32000000, 32'hABCD00 << 0 | 32'h00ABCD00, 6'd24, 16'd0, 16'd32, 4'b0100, 2);
        check("pp_txbits", x.txw, 32'h12345678);
        check("pp_beats", 32'(x.beats), 32'd1);
        check("pp_rx_ready", 32'(x.rxr), 32'd0);
        serve(32'h01, 1'b0, x);
        chk_x("pp_poll1", x, 32'h05000000, 32'h0, 6'd0, 16'd0, 16'd8, 4'b0001, 2);
        serve(32'h01, 1'b0, x);
        chk_x("pp_poll2", x, 32'h05000000, 32'h0, 6'd0, 16'd0, 16'd8, 4'b0001, 3);
        serve(32'h00, 1'b0, x);
        chk_x("pp_poll3", x, 32'h05000000, 32'h0, 6'd0, 16'd0, 16'd8, 4'b0001, 3);
        get_resp("pp", 0, rd, er, lat);
        check("pp_err", 32'(er), 32'd0);
        check("pp_latency", 32'(lat), 32'd1);

        // ERASE with WIP stuck; POLL_MAX = 4
        do_req(2'b11, 1'b0, 24'h001000, 32'h0);
        serve(32'h0, 1'b0, x);
        chk_x("er_wren", x, 32'h06000000, 32'h0, 6'd0, 16'd0, 16'd0, 4'b1000, 0);
        serve(32'h0, 1'b0, x);
        chk_x("er_op", x, 32'h20000000, 32'h00100000, 6'd24, 16'd0, 16'd0, 4'b1000, 2);
        for (int i = 0; i < 4; i++) begin
            serve(32'h01, 1'b0, x);
            check("er_poll_cmd", x.cmd, 32'h05000000);
            check("er_poll_strobe", 32'(x.stb), 32'b0010);
        end
        get_resp("er", 0, rd, er, lat);
        check("er_err", 32'(er), 32'd1);

        // READ_STATUS with a stalled response
        do_req(2'b10, 1'b0, 24'h123456, 32'h0);
        serve(32'h000000A5, 1'b0, x);
        chk_x("rs", x, 32'h05000000, 32'h0, 6'd0, 16'd0, 16'd8, 4'b0010, 0);
        get_resp("rs", 5, rd, er, lat);
        check("rs_rdata", rd, 32'h000000A5);
        check("rs_err", 32'(er), 32'd0);

        // Quad READ at top address with stray done pulses
        do_req(2'b00, 1'b1, 24'hFFFFFF, 32'h0);
        serve(32'hCAFEF00D, 1'b1, x);
        chk_x("qrd", x, 32'h6B000000, 32'hFFFFFF00, 6'd24, 16'd10, 16'd32, 4'b0001, 0);
        get_resp("qrd", 0, rd, er, lat);
        check("qrd_rdata", rd, 32'hCAFEF00D);

        // Reset during the PROGRAM data phase
        do_req(2'b01, 1'b0, 24'h0003F0, 32'hDEADBEEF);
        serve(32'h0, 1'b0, x);
        check("rst_wren_cmd", x.cmd, 32'h06000000);
        guard = 0;
        while (stb_now() == 4'b0 && guard < 50) begin tick(); guard++; end
        check("rst_pp_strobe", 32'(stb_now()), 32'b1000);
        tick();
        check("rst_pp_txvalid", 32'(m_tx_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_outputs", any_out(), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        check("rst_release_ready", 32'(req_ready), 32'd1);
        check("rst_no_resp", 32'(resp_valid), 32'd0);
        do_req(2'b00, 1'b0, 24'h000010, 32'h0);
        serve(32'h0BADCAFE, 1'b0, x);
        chk_x("post_rd", x, 32'h03000000, 32'h00001000, 6'd24, 16'd0, 16'd32, 4'b0010, 0);
        get_resp("post_rd", 0, rd, er, lat);
        check("post_rd_rdata", rd, 32'h0BADCAFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/qspi_flash_sequencer.md
# qspi_flash_sequencer

Command sequencer that sits directly upstream of `qspi_master`. It turns single-word host requests (read, program, subsector erase, read status) into the transaction sequence the flash needs. It issues WRITE ENABLE before every program or erase, and polls the status register until the write-in-progress bit clears. It drives the master's descriptor and strobe inputs and consumes its tx/rx handshakes and done pulses.

## Interface
- POLL_MAX, 1023: maximum status polls after a program or erase before the request fails with a timeout error.
- DUMMY_CYCLES, 10: value driven on `m_dummy_len` for quad reads; matches the non-volatile configuration register setting.
- `clock` input 1: single clock; every register is on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1, `req_ready` output 1: request handshake; a request is accepted when both are 1 on a rising clock edge.
- `req_op` input 2: operation. 00 = READ, 01 = PROGRAM, 10 = READ_STATUS, 11 = SUBSECTOR_ERASE.
- `req_quad` input 1: 1 selects the quad command and quad strobe variants.
- `req_addr` input 24: flash byte address.
- `req_wdata` input 32: program word, sent MSB first.
- `resp_valid` output 1, `resp_ready` input 1: response handshake.
- `resp_rdata` output 32: read word, or the status byte zero-extended.
- `resp_err` output 1: 1 when status polling timed out.
- `m_cmd` output 32, `m_cmd_len` output 6: command byte left-justified in `m_cmd`, with its bit length.
- `m_addr` output 32, `m_addr_len` output 6: address as {`req_addr`, 8'h00}, with length 24 or 0.
- `m_dummy_len` output 16, `m_data_len` output 16: dummy length and data length in bits.
- `m_wr`, `m_rd`, `m_qwr`, `m_qrd` outputs, 1 each: transaction strobes to the master.
- `m_tx_valid` output 1, `m_tx_bits` output 32, `m_tx_ready` input 1: transmit data handshake.
- `m_rx_valid` input 1, `m_rx_bits` input 32, `m_rx_ready` output 1: receive data handshake.
- `m_tx_done` input 1, `m_rx_done` input 1: one-cycle completion pulses from the master.

## Operation
- States: IDLE, WREN, OP, POLL, CHECK, GAP, RESP.
- Each sub-transaction has two phases.
  - ISSUE: descriptor fields and exactly one strobe are driven.
  - WAIT: fields and strobe are held stable until the done pulse; `m_tx_done` ends writes, `m_rx_done` ends reads.
  - The strobe drops in the cycle after the done pulse.
- Sub-transaction encodings (strobe is the quad variant when `req_quad` = 1):

  | Name | `m_cmd` | `m_cmd_len` | Address | Dummy | Data | Strobe |
  |---|---|---|---|---|---|---|
  | WREN | 0x06 | 8 | none | 0 | 0 | `m_wr` / `m_qwr` |
  | PROGRAM | 0x02 (0x32 if quad) | 8 | 24-bit | 0 | 32 tx bits | `m_wr` / `m_qwr` |
  | ERASE | 0x20 | 8 | 24-bit | 0 | 0 | `m_wr` / `m_qwr` |
  | READ | 0x03 (0x6B if quad) | 8 | 24-bit | DUMMY_CYCLES (quad only) | 32 rx bits | `m_rd` / `m_qrd` |
  | RDSR | 0x05 | 8 | none | 0 | 8 rx bits | `m_rd` / `m_qrd` |

- Flow by request type:
  - READ and READ_STATUS: IDLE → OP → RESP.
  - PROGRAM and ERASE: IDLE → WREN → GAP → OP → GAP → POLL → CHECK.
  - CHECK: WIP = `m_rx_bits[0]` captured during the poll. WIP = 0 → RESP. WIP = 1 → GAP → POLL, and the poll counter increments.
  - When the poll counter reaches POLL_MAX with WIP still 1 → RESP with `resp_err` = 1.
- GAP holds every strobe low for exactly 2 cycles so the master deasserts CS between sub-transactions.
- Data handshakes:
  - `m_tx_valid` is 1 from the start of PROGRAM WAIT until the first `m_tx_ready`; exactly one beat is sent. `m_tx_bits` = the latched `req_wdata`.
  - `m_rx_ready` is 1 only in the WAIT phase of read-type sub-transactions. The first `m_rx_valid` beat is captured; later beats in the same sub-transaction are ignored.
- RESP: `resp_valid` = 1 until `resp_ready`, then → IDLE. The poll counter clears on request accept.

## Timing
- Reset values: `req_ready` = 0 while reset is asserted and 1 in IDLE after release. Every other output is 0, including the strobes, `m_cmd`, `m_tx_valid`, `m_rx_ready` and `resp_*`.
- Request acceptance:
  - `req_ready` = 1 only in IDLE.
  - All request fields are latched on accept.
  - ISSUE begins the cycle after accept.
- Strobe timing: fields and strobe are registered and change only on state transitions, never mid-WAIT.
- Simultaneous `m_tx_done` and `m_rx_done`: only the one matching the current sub-transaction type is honoured.
- A done pulse outside WAIT is ignored.
- Minimum latency for READ: accept → ISSUE at +1 cycle; `resp_valid` appears 1 cycle after `m_rx_done`.
- Response handshake: `resp_valid` falls the cycle after `resp_ready` is sampled high. `resp_ready` held high permanently gives a 1-cycle response.
- Reset asserted mid-operation: strobes, `m_tx_valid` and `m_rx_ready` drop asynchronously. The request in flight is lost and no response is produced.

## Test plan
- READ, `req_quad` = 0, addr 0x000600; bench master returns 0x12345678 → `m_cmd` = 0x03000000, `m_addr` = 0x00060000, `m_data_len` = 32, `m_rd` = 1; response `resp_rdata` = 0x12345678, `resp_err` = 0.
- PROGRAM quad, data 0x12345678; status reads return 0x01, 0x01, 0x00 → sequence WREN (`m_qwr`, 0x06), PP 0x32 with one tx beat, then 3 RDSR polls; `resp_err` = 0; 2-cycle strobe gaps between sub-transactions.
- ERASE with WIP stuck at 1 and POLL_MAX = 4 → exactly 4 polls, then `resp_valid` = 1 with `resp_err` = 1.
- READ_STATUS, `m_rx_bits` = 0x000000A5 → `resp_rdata` = 0x000000A5; `resp_ready` held low for 5 cycles → `resp_valid` stays 1 and `req_ready` stays 0 throughout.
- Quad READ → `m_dummy_len` = 10 and `m_qrd` = 1. A stray `m_tx_done` during WAIT is ignored; the sub-transaction finishes only on `m_rx_done`.
- Reset asserted during the PROGRAM data phase → all outputs 0 immediately; after release, `req_ready` = 1 and a new READ completes normally.
